// File: rtl/layer_lut_sequencer_if.sv
// Valid/ready input and output channels plus the config write port of layer_lut_sequencer.
// cfg_rdata exists only when LAYER_SEQ_CFG_READBACK_EN is defined.
interface layer_lut_sequencer_if #(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned IN_FEATURES = 16,
    parameter int unsigned FAN_IN      = 4,
    parameter int unsigned IN_BW       = 2,
    parameter int unsigned OUT_BW      = 2
);
    localparam int unsigned IDX_W  = $clog2(IN_FEATURES);
    localparam int unsigned TA_W   = FAN_IN * IN_BW;
    localparam int unsigned NI_W   = $clog2(NUM_NEURONS);
    localparam int unsigned CFG_AW = NI_W + TA_W;
    localparam int unsigned CFG_DW = (OUT_BW > IDX_W) ? OUT_BW : IDX_W;

    logic                            in_valid;
    logic                            in_ready;
    logic [IN_FEATURES*IN_BW-1:0]    in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BW-1:0]   out_data;
    logic                            cfg_we;
    logic                            cfg_ready;
    logic                            cfg_sel;
    logic [CFG_AW-1:0]               cfg_addr;
    logic [CFG_DW-1:0]               cfg_wdata;
`ifdef LAYER_SEQ_CFG_READBACK_EN
    logic [CFG_DW-1:0]               cfg_rdata;
`endif

    modport master (
`ifdef LAYER_SEQ_CFG_READBACK_EN
        input  cfg_rdata,
`endif
        output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data, cfg_ready
    );

    modport slave (
`ifdef LAYER_SEQ_CFG_READBACK_EN
        output cfg_rdata,
`endif
        input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data, cfg_ready
    );
endinterface

// File: rtl/layer_lut_sequencer.sv
// Time-multiplexed LogicNets layer: one shared truth-table memory and one connectivity
// memory, neurons evaluated one per cycle through a two-stage gather/lookup pipeline.
// Optional macro LAYER_SEQ_CFG_READBACK_EN adds a registered cfg_rdata readback port.
module layer_lut_sequencer #(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned IN_FEATURES = 16,
    parameter int unsigned FAN_IN      = 4,
    parameter int unsigned IN_BW       = 2,
    parameter int unsigned OUT_BW      = 2
) (
    input logic             clk,
    input logic             rst,
    layer_lut_sequencer_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(IN_FEATURES);
    localparam int unsigned TA_W   = FAN_IN * IN_BW;
    localparam int unsigned NI_W   = $clog2(NUM_NEURONS);
    localparam int unsigned SLOT_W = $clog2(FAN_IN);
    localparam int unsigned CFG_AW = NI_W + TA_W;
    localparam int unsigned CN_AW  = NI_W + SLOT_W;
    localparam int unsigned K_W    = NI_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // k runs past N-1: k=N lets the last lookup land, k=N+1 is the drain cycle.
    localparam logic [K_W-1:0] K_ISSUE_END = K_W'(NUM_NEURONS);
    localparam logic [K_W-1:0] K_LAST      = K_W'(NUM_NEURONS + 1);

    logic [OUT_BW-1:0]              tbl  [2**CFG_AW];
    logic [IDX_W-1:0]               conn [2**CN_AW];

    logic [1:0]                     state_q;
    logic [K_W-1:0]                 k_q;
    logic [IN_FEATURES*IN_BW-1:0]   in_q;
    logic [TA_W-1:0]                ta_q;
    logic [NI_W-1:0]                nk_q;
    logic                           s1_q;
    logic [NUM_NEURONS*OUT_BW-1:0]  out_q;

    logic [TA_W-1:0]                ta_d;
    logic [IDX_W-1:0]               fidx;
    logic                           run_issue;
    logic                           cfg_commit;
    logic                           accept;

    assign bus.in_ready  = (state_q == ST_IDLE) && !bus.cfg_we;
    assign bus.cfg_ready = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign cfg_commit = (state_q == ST_IDLE) && bus.cfg_we;
    assign run_issue  = (state_q == ST_RUN) && (k_q < K_ISSUE_END);

    // Stage 1: gather neuron k's fan-in features into a table address, slot 0 in the MSBs.
    always_comb begin
        ta_d = '0;
        fidx = '0;
        for (int s = 0; s < FAN_IN; s++) begin
            fidx = conn[{k_q[NI_W-1:0], SLOT_W'(s)}];
            ta_d[(FAN_IN-1-s)*IN_BW +: IN_BW] = in_q[fidx*IN_BW +: IN_BW];
        end
    end

    // Control FSM: accept a vector, count neurons through RUN, hold the result in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            in_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_q    <= bus.in_data;
                        k_q     <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == K_LAST) state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 register and stage 2 synchronous lookup straight into the result slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            ta_q  <= '0;
            nk_q  <= '0;
            out_q <= '0;
        end else begin
            s1_q <= run_issue;
            if (run_issue) begin
                ta_q <= ta_d;
                nk_q <= k_q[NI_W-1:0];
            end
            if (s1_q) out_q[nk_q*OUT_BW +: OUT_BW] <= tbl[{nk_q, ta_q}];
        end
    end

    // Config writes commit only in IDLE; memories are deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_commit) begin
            if (!bus.cfg_sel) tbl[bus.cfg_addr] <= bus.cfg_wdata[OUT_BW-1:0];
            else              conn[bus.cfg_addr[CN_AW-1:0]] <= bus.cfg_wdata[IDX_W-1:0];
        end
    end

`ifdef LAYER_SEQ_CFG_READBACK_EN
    localparam int unsigned CFG_DW = (OUT_BW > IDX_W) ? OUT_BW : IDX_W;
    logic [CFG_DW-1:0] rdata_q;

    // Readback: entry addressed in an idle, non-writing cycle appears one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state_q == ST_IDLE) && !bus.cfg_we) begin
            rdata_q <= bus.cfg_sel ? CFG_DW'(conn[bus.cfg_addr[CN_AW-1:0]])
                                   : CFG_DW'(tbl[bus.cfg_addr]);
        end else begin
            rdata_q <= '0;
        end
    end

    assign bus.cfg_rdata = (state_q == ST_IDLE) ? rdata_q : '0;
`endif
endmodule
